// File: rtl/mult_sequencer_if.sv
// EX-stage multiply handshake: instruction/operands in, stall/done/result out.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [3:0]       ALUCtrl_i;
  logic             flush_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             stall_o;
  logic             done_o;
  logic             busy_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output valid_i, ALUCtrl_i, flush_i, data1_i, data2_i,
    input  stall_o, done_o, busy_o, result_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, flush_i, data1_i, data2_i,
    output stall_o, done_o, busy_o, result_o
  );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add MUL sequencer for the EX stage: stalls the pipeline while it walks
// the multiplier one bit per cycle, then presents the low WIDTH product bits.
module mult_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mult_sequencer_if.slave  bus
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0]      OP_MUL   = 4'b0011;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] mplier_shr;
  logic [CNT_W-1:0] cnt;
  logic             start, last_iter;
  logic             stall, done, busy;
  logic [WIDTH-1:0] result;

  // Gating with rst_i keeps every output low while reset is held, even if a MUL is presented.
  assign start      = rst_i & bus.valid_i & (bus.ALUCtrl_i == OP_MUL) & ~bus.flush_i;
  assign mplier_shr = mplier >> 1;
  assign last_iter  = (cnt == CNT_LAST) || (EARLY_EXIT && (mplier_shr == '0));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    busy      = (state == RUN);
    result    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          stall     = 1'b1;
        end
      end
      RUN: begin
        if (bus.flush_i) begin
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
          if (last_iter) state_nxt = DONE;
        end
      end
      DONE: begin
        // The retiring MUL is still in EX here, so start is deliberately not sampled.
        state_nxt = IDLE;
        if (!bus.flush_i) begin
          done   = 1'b1;
          result = acc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= bus.data1_i;
            mplier <= bus.data2_i;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (bus.flush_i) begin
            acc <= '0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier_shr;
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.flush_i) acc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_o  = stall;
  assign bus.done_o   = done;
  assign bus.busy_o   = busy;
  assign bus.result_o = result;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: one instance per EARLY_EXIT setting, checked against
// a product/latency model computed directly from operand values.
module tb_mult_sequencer;

  localparam logic [3:0] MUL = 4'b0011;
  localparam logic [3:0] ADD = 4'b0010;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk_i = ~clk_i;

  mult_sequencer_if #(.WIDTH(32)) if0 ();
  mult_sequencer_if #(.WIDTH(32)) if1 ();

  mult_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) u_dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0));
  mult_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) u_dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1));

  // Reference model: product modulo 2^32 and stall length from the multiplier's top set bit.
  function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return p[31:0];
  endfunction

  function automatic int model_stall(input bit ee, input logic [31:0] b);
    int n;
    if (!ee) return 33;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return 1 + ((n == 0) ? 1 : n);
  endfunction

  task automatic drive(input bit ee, input logic v, input logic [3:0] op, input logic fl,
                       input logic [31:0] a, input logic [31:0] b);
    if (ee) begin
      if1.valid_i = v; if1.ALUCtrl_i = op; if1.flush_i = fl; if1.data1_i = a; if1.data2_i = b;
    end else begin
      if0.valid_i = v; if0.ALUCtrl_i = op; if0.flush_i = fl; if0.data1_i = a; if0.data2_i = b;
    end
  endtask

  task automatic sample(input bit ee, output logic st, output logic dn, output logic bs,
                        output logic [31:0] r);
    if (ee) begin
      st = if1.stall_o; dn = if1.done_o; bs = if1.busy_o; r = if1.result_o;
    end else begin
      st = if0.stall_o; dn = if0.done_o; bs = if0.busy_o; r = if0.result_o;
    end
  endtask

  // Issues one MUL and holds it until done_o; returns the observed timing and result.
  task automatic run_mul(input bit ee, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                         output int stalls, output int busys, output int done_at, output logic [31:0] res);
    logic st, dn, bs;
    logic [31:0] r;
    stalls = 0; busys = 0; done_at = -1; res = '0;
    @(posedge clk_i); #1;
    drive(ee, 1'b1, MUL, 1'b0, a, b);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_i);
      sample(ee, st, dn, bs, r);
      if (dn) begin
        done_at = c; res = r;
        break;
      end
      if (st) stalls++;
      if (bs) busys++;
      @(posedge clk_i); #1;
      if (scramble) drive(ee, 1'b1, 4'($urandom_range(0, 15)), 1'b0, $urandom, $urandom);
    end
    @(posedge clk_i); #1;
    drive(ee, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    logic st, dn, bs;
    logic [31:0] r;
    rst_i = 1'b0;
    drive(0, 1'b1, MUL, 1'b0, 32'd7, 32'd6);
    drive(1, 1'b1, MUL, 1'b0, 32'd7, 32'd6);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    for (int ee = 0; ee < 2; ee++) begin
      sample(ee[0], st, dn, bs, r);
      total++;
      if ({st, dn, bs, r} !== 35'd0)
        $display("FAIL reset_outputs ee=%0d: got stall=%b done=%b busy=%b result=%h, want all 0", ee, st, dn, bs, r);
      else passed++;
    end
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic test_basic();
    int s, b, d;
    logic [31:0] r;
    logic st, dn, bs;
    run_mul(0, 32'd7, 32'd6, 1'b0, s, b, d, r);
    total++; if (s !== 33) $display("FAIL basic_stall: got %0d cycles, want 33", s); else passed++;
    total++; if (d !== 33) $display("FAIL basic_done_at: got cycle %0d, want 33", d); else passed++;
    total++; if (b !== 32) $display("FAIL basic_busy: got %0d cycles, want 32", b); else passed++;
    total++; if (r !== 32'd42) $display("FAIL basic_result: got %0d, want 42", r); else passed++;
    @(negedge clk_i);
    sample(0, st, dn, bs, r);
    total++;
    if ({st, dn, bs, r} !== 35'd0)
      $display("FAIL basic_after_done: got stall=%b done=%b busy=%b result=%h, want all 0", st, dn, bs, r);
    else passed++;
  endtask

  task automatic test_overflow();
    int s, b, d;
    logic [31:0] r;
    run_mul(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, s, b, d, r);
    total++; if (r !== 32'h0000_0001) $display("FAIL ovf_ones: got %h, want 00000001", r); else passed++;
    run_mul(0, 32'h0001_0000, 32'h0001_0000, 1'b0, s, b, d, r);
    total++; if (r !== 32'h0) $display("FAIL ovf_wrap: got %h, want 00000000", r); else passed++;
    total++; if (d !== 33) $display("FAIL ovf_done_at: got cycle %0d, want 33", d); else passed++;
  endtask

  task automatic test_early_exit();
    int s, b, d;
    logic [31:0] r;
    logic [31:0] a;
    run_mul(1, 32'd1234, 32'd0, 1'b0, s, b, d, r);
    total++; if (s !== 2) $display("FAIL ee_zero_stall: got %0d cycles, want 2", s); else passed++;
    total++; if (r !== 32'd0) $display("FAIL ee_zero_result: got %h, want 0", r); else passed++;
    a = $urandom;
    run_mul(1, a, 32'd5, 1'b0, s, b, d, r);
    total++; if (s !== 4) $display("FAIL ee_five_stall: got %0d cycles, want 4", s); else passed++;
    total++; if (r !== model_prod(a, 32'd5)) $display("FAIL ee_five_result: got %h, want %h", r, model_prod(a, 32'd5)); else passed++;
    run_mul(1, a, 32'h8000_0000, 1'b0, s, b, d, r);
    total++; if (s !== 33) $display("FAIL ee_msb_stall: got %0d cycles, want 33", s); else passed++;
  endtask

  task automatic test_non_mul();
    logic st, dn, bs;
    logic [31:0] r;
    @(posedge clk_i); #1;
    drive(0, 1'b1, ADD, 1'b0, 32'd9, 32'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      sample(0, st, dn, bs, r);
      total++;
      if ({st, dn, bs} !== 3'b000)
        $display("FAIL add_bypass c=%0d: got stall=%b done=%b busy=%b, want 000", c, st, dn, bs);
      else passed++;
    end
    @(posedge clk_i); #1;
    drive(0, 1'b1, MUL, 1'b1, 32'd9, 32'd9);
    @(negedge clk_i);
    sample(0, st, dn, bs, r);
    total++; if (st !== 1'b0) $display("FAIL flush_start_stall: got %b, want 0", st); else passed++;
    @(posedge clk_i); #1;
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk_i);
    sample(0, st, dn, bs, r);
    total++; if (bs !== 1'b0) $display("FAIL flush_start_busy: got %b, want 0", bs); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int s, b, d;
    logic st, dn, bs;
    logic [31:0] r;
    @(posedge clk_i); #1;
    drive(0, 1'b1, MUL, 1'b0, 32'hABCD, 32'h1234);
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1 sample(0, st, dn, bs, r);
    total++;
    if ({st, dn, bs, r} !== 35'd0)
      $display("FAIL midrun_reset: got stall=%b done=%b busy=%b result=%h, want all 0", st, dn, bs, r);
    else passed++;
    @(negedge clk_i);
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    rst_i = 1'b1;
    run_mul(0, 32'd3, 32'd4, 1'b0, s, b, d, r);
    total++; if (r !== 32'd12) $display("FAIL midrun_next_result: got %0d, want 12", r); else passed++;
    total++; if (d !== 33) $display("FAIL midrun_next_done_at: got cycle %0d, want 33", d); else passed++;
  endtask

  task automatic test_flush();
    logic st, dn, bs;
    logic [31:0] r;
    bit seen;
    @(posedge clk_i); #1;
    drive(0, 1'b1, MUL, 1'b0, 32'd11, 32'd13);
    repeat (5) @(posedge clk_i);
    #1 drive(0, 1'b1, MUL, 1'b1, 32'd11, 32'd13);
    @(negedge clk_i);
    sample(0, st, dn, bs, r);
    total++;
    if ({st, dn} !== 2'b00) $display("FAIL flush_run_cycle: got stall=%b done=%b, want 00", st, dn);
    else passed++;
    @(posedge clk_i); #1;
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      sample(0, st, dn, bs, r);
      if (dn || st || bs) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL flush_run_quiet: got activity after flush, want none"); else passed++;
    // Flush in the DONE cycle of an EARLY_EXIT multiply with a one-cycle RUN.
    @(posedge clk_i); #1;
    drive(1, 1'b1, MUL, 1'b0, 32'd77, 32'd1);
    repeat (model_stall(1, 32'd1)) @(posedge clk_i);
    #1 sample(1, st, dn, bs, r);
    total++; if (dn !== 1'b1) $display("FAIL flush_done_reached: got done=%b, want 1", dn); else passed++;
    drive(1, 1'b1, MUL, 1'b1, 32'd77, 32'd1);
    #1 sample(1, st, dn, bs, r);
    total++;
    if ({st, dn, r} !== 34'd0) $display("FAIL flush_done_cycle: got stall=%b done=%b result=%h, want all 0", st, dn, r);
    else passed++;
    @(posedge clk_i); #1;
    drive(1, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk_i);
    sample(1, st, dn, bs, r);
    total++;
    if ({st, dn, bs} !== 3'b000) $display("FAIL flush_done_idle: got stall=%b done=%b busy=%b, want 000", st, dn, bs);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic st, dn, bs;
    logic [31:0] r, r1, r2;
    int t1, t2;
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    @(posedge clk_i); #1;
    drive(0, 1'b1, MUL, 1'b0, 32'd2, 32'd3);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk_i);
      sample(0, st, dn, bs, r);
      if (dn && t1 < 0) begin
        t1 = c; r1 = r;
      end else if (dn) begin
        t2 = c; r2 = r;
        break;
      end
      @(posedge clk_i); #1;
      if (t1 == c) drive(0, 1'b1, MUL, 1'b0, 32'd4, 32'd5);
    end
    @(posedge clk_i); #1;
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    total++; if (t1 !== model_stall(0, 32'd3)) $display("FAIL b2b_first_at: got %0d, want 33", t1); else passed++;
    total++; if (r1 !== model_prod(32'd2, 32'd3)) $display("FAIL b2b_first_result: got %0d, want 6", r1); else passed++;
    total++; if (t2 - t1 !== 34) $display("FAIL b2b_spacing: got %0d cycles, want 34", t2 - t1); else passed++;
    total++; if (r2 !== model_prod(32'd4, 32'd5)) $display("FAIL b2b_second_result: got %0d, want 20", r2); else passed++;
  endtask

  task automatic test_random();
    int s, b, d, es;
    logic [31:0] r, a, m;
    for (int ee = 0; ee < 2; ee++) begin
      for (int i = 0; i < 6; i++) begin
        a = $urandom;
        m = $urandom;
        if (ee == 1) m = m >> $urandom_range(0, 32);
        es = model_stall(ee[0], m);
        run_mul(ee[0], a, m, i[0], s, b, d, r);
        total++;
        if (r !== model_prod(a, m))
          $display("FAIL rand_result ee=%0d a=%h b=%h: got %h, want %h", ee, a, m, r, model_prod(a, m));
        else passed++;
        total++;
        if (s !== es || d !== es || b !== es - 1)
          $display("FAIL rand_timing ee=%0d b=%h: got stall=%0d done_at=%0d busy=%0d, want %0d/%0d/%0d",
                   ee, m, s, d, b, es, es, es - 1);
        else passed++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_early_exit();
    test_non_mul();
    test_reset_mid_run();
    test_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
